uart_rx_deser_v2: RTL and testbench
===================================

UART_RX_DESER_V2 -- requirements
Module: uart_rx_deser_v2

Interface
REQ-001 Parameter MAX_WIDTH, default 9, SHALL set the widest supported word; the legal range is 5..16.
REQ-002 Parameter CNT_W, default 6, SHALL set the width of Prescale and edgecount.
REQ-003 Clk  in  1  SHALL be the clock; all state updates occur on its rising edge.
REQ-004 Rst  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 Sampled_bit  in  1  SHALL carry the majority-voted RX bit.
REQ-006 Deser_en  in  1  SHALL be the data-phase enable from the RX FSM.
REQ-007 Prescale  in  CNT_W  SHALL give the oversampling ratio.
REQ-008 edgecount  in  CNT_W  SHALL give the current oversample edge index.
REQ-009 Data_len  in  4  SHALL give the number of data bits per word.
REQ-010 Msb_first  in  1  SHALL select bit order: 1 = MSB-first, 0 = LSB-first.
REQ-011 Par_type  in  1  SHALL select parity sense: 0 = even, 1 = odd.
REQ-012 Rdy  in  1  SHALL be the downstream ready signal.
REQ-013 P_Data  out  MAX_WIDTH  SHALL be the assembled word, right-justified.
REQ-014 Data_valid  out  1  SHALL indicate that P_Data holds an unconsumed word.
REQ-015 Exp_par  out  1  SHALL be the expected parity bit for P_Data.
REQ-016 Frag_err  out  1  SHALL be a 1-cycle pulse marking an aborted (partial) word.
REQ-017 Overrun  out  1  SHALL be a 1-cycle pulse marking an unconsumed word that was overwritten.

Function
REQ-018 tick SHALL equal Deser_en AND (edgecount == Prescale-1), computed modulo 2^CNT_W, so that Prescale=0 compares against all-ones.
REQ-019 The FSM SHALL have three states, IDLE, SHIFT and WAIT_DROP, with the following behaviour:
- IDLE: clear the shift register and bit count; on Deser_en=1, latch the length (len), Msb_first and Par_type, then go to SHIFT. A tick occurring in that same cycle counts as bit 0.
- SHIFT: on each tick, shift in Sampled_bit and increment the bit count.
- WAIT_DROP: ignore ticks; return to IDLE when Deser_en=0.
REQ-020 Shift direction:
- LSB-first: sh <= {bit, sh[MAX_WIDTH-1:1]}, and the completed word SHALL be shifted right by MAX_WIDTH-len.
- MSB-first: sh <= {sh[MAX_WIDTH-2:0], bit}.
- In both modes, bits above len-1 SHALL be zero.
REQ-021 A Data_len value below 5 or above MAX_WIDTH SHALL be treated as MAX_WIDTH.
REQ-022 The latched len, order and parity settings SHALL stay fixed for the whole word; input changes take effect only at the next IDLE->SHIFT transition.
REQ-023 On the tick that captures bit len-1, the block SHALL go to WAIT_DROP. On the next edge it SHALL load P_Data and Exp_par and set Data_valid=1 (latency: 1 cycle after the final tick).
REQ-024 Exp_par SHALL equal the XOR of the len data bits, inverted when Par_type=1. It SHALL be accumulated incrementally per tick.
REQ-025 Data_valid SHALL clear on any edge where Data_valid=1 and Rdy=1, unless a new word loads in the same cycle. P_Data and Exp_par SHALL hold their values while Data_valid=1.
REQ-026 A word completing while Data_valid=1 and Rdy=0 SHALL overwrite P_Data and Exp_par, keep Data_valid=1, and pulse Overrun.
REQ-027 A word completing in the same cycle as an acceptance SHALL load the new word, keep Data_valid=1, and SHALL NOT pulse Overrun.
REQ-028 Deser_en falling while in SHIFT SHALL discard the partial word, pulse Frag_err, and return to IDLE, leaving P_Data and Data_valid unchanged.
REQ-029 Ticks occurring outside SHIFT SHALL have no effect.

Reset
REQ-030 While Rst=0, all outputs and internal state SHALL be 0 and the FSM SHALL be in IDLE.
REQ-031 Reset asserted mid-word SHALL lose the partial word and SHALL NOT produce a Frag_err pulse.
REQ-032 After reset release, no word SHALL start until Deser_en is sampled high.

Structure
REQ-033 Package uart_rx_pkg SHALL hold the FSM state enum, MIN_LEN=5, and the PAR_EVEN/PAR_ODD constants.
REQ-034 Sub-module uart_par_acc SHALL implement the per-tick clearable XOR parity accumulator, with the Par_type inversion applied at load time.

Verification
REQ-035 Prescale=8, len=8, LSB-first, even parity, bits 1,0,1,0,0,1,0,1 at edgecount=7 -> P_Data=0x0A5, Exp_par=0, Data_valid high 1 cycle after the 8th tick.
REQ-036 len=7, MSB-first, odd parity, bits 1,0,1,1,0,1,0 -> P_Data=0x05A, Exp_par=1. Then len=5, LSB-first, bits 1,1,0,0,1 -> P_Data=0x013, bits 8:5 zero.
REQ-037 Deser_en dropped after 3 ticks -> Frag_err pulses for 1 cycle; Data_valid and P_Data keep their prior values. The next full word is assembled correctly.
REQ-038 Rdy=0 with two back-to-back words 0x0A5 then 0x03C -> Overrun pulses once, P_Data=0x03C, Data_valid=1. Rdy=1 in the completion cycle -> no Overrun.
REQ-039 Prescale=0 with ticks at edgecount=63 -> the word is assembled normally. Data_len=2 -> treated as MAX_WIDTH (9 ticks needed).
REQ-040 Rst pulled low after 4 ticks -> all outputs 0 asynchronously, no Frag_err pulse. A new word after release assembles correctly.

Source files
------------

// File: rtl/uart_rx_deser_v2_pkg.sv
// Shared types and constants for the UART RX deserializer slice.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT     = 2'd1,
    WAIT_DROP = 2'd2
  } state_e;

  localparam int   MIN_LEN  = 5;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_deser_v2_if.sv
// Bundle between the RX front end / consumer and the deserializer.
interface uart_rx_deser_v2_if #(
  parameter int MAX_WIDTH = 9,
  parameter int CNT_W     = 6
);

  logic                 Sampled_bit;
  logic                 Deser_en;
  logic [CNT_W-1:0]     Prescale;
  logic [CNT_W-1:0]     edgecount;
  logic [3:0]           Data_len;
  logic                 Msb_first;
  logic                 Par_type;
  logic                 Rdy;
  logic [MAX_WIDTH-1:0] P_Data;
  logic                 Data_valid;
  logic                 Exp_par;
  logic                 Frag_err;
  logic                 Overrun;

  modport master (
    output Sampled_bit, Deser_en, Prescale, edgecount, Data_len,
           Msb_first, Par_type, Rdy,
    input  P_Data, Data_valid, Exp_par, Frag_err, Overrun
  );

  modport slave (
    input  Sampled_bit, Deser_en, Prescale, edgecount, Data_len,
           Msb_first, Par_type, Rdy,
    output P_Data, Data_valid, Exp_par, Frag_err, Overrun
  );

endinterface

// File: rtl/uart_rx_deser_v2_par_acc.sv
// Running XOR of the data bits of one word; odd-parity inversion is applied
// on the output so the value can be loaded directly.
module uart_par_acc
  import uart_rx_pkg::*;
(
  input  logic Clk,
  input  logic Rst,
  input  logic clear,
  input  logic en,
  input  logic sample,
  input  logic par_type,
  output logic par
);

  logic acc;

  // A clear cycle that also carries a tick starts the sum with that bit.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)
      acc <= 1'b0;
    else if (clear)
      acc <= en & sample;
    else if (en)
      acc <= acc ^ sample;
  end

  assign par = acc ^ (par_type == PAR_ODD);

endmodule

// File: rtl/uart_rx_deser_v2.sv
// UART RX deserializer: assembles ticked bits into a right-justified word
// with parity, valid/ready hold, overrun and fragment reporting.
module uart_rx_deser_v2
  import uart_rx_pkg::*;
#(
  parameter int MAX_WIDTH = 9,
  parameter int CNT_W     = 6
) (
  input logic             Clk,
  input logic             Rst,
  uart_rx_deser_v2_if.slave bus
);

  localparam int LEN_W = $clog2(MAX_WIDTH + 1);

  state_e               state_q, state_d;
  logic [MAX_WIDTH-1:0] sh_q, sh_d, word;
  logic [LEN_W-1:0]     cnt_q, cnt_d, len_q, len_d, len_sel;
  logic                 msb_q, msb_d, par_q, par_d;
  logic                 done_q, done_d, frag_d;
  logic                 tick, acc_clear, acc_en, par_word;
  logic [CNT_W-1:0]     last_edge;
  logic [MAX_WIDTH-1:0] p_data;
  logic                 data_valid, exp_par, frag_err, overrun;

  // Prescale=0 wraps to all-ones so the last oversample edge is 2^CNT_W-1.
  assign last_edge = bus.Prescale - CNT_W'(1);
  assign tick      = bus.Deser_en && (bus.edgecount == last_edge);

  assign len_sel = (int'(bus.Data_len) < MIN_LEN || int'(bus.Data_len) > MAX_WIDTH)
                   ? LEN_W'(MAX_WIDTH) : LEN_W'(bus.Data_len);

  assign word = msb_q ? sh_q : (sh_q >> (LEN_W'(MAX_WIDTH) - len_q));

  assign acc_clear = (state_q == IDLE);
  assign acc_en    = tick && (state_q != WAIT_DROP);

  uart_par_acc u_par_acc (
    .Clk      (Clk),
    .Rst      (Rst),
    .clear    (acc_clear),
    .en       (acc_en),
    .sample   (bus.Sampled_bit),
    .par_type (par_q),
    .par      (par_word)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      msb_q   <= 1'b0;
      par_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      msb_q   <= msb_d;
      par_q   <= par_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    msb_d   = msb_q;
    par_d   = par_q;
    done_d  = 1'b0;
    frag_d  = 1'b0;
    case (state_q)
      IDLE: begin
        sh_d  = '0;
        cnt_d = '0;
        if (bus.Deser_en) begin
          len_d   = len_sel;
          msb_d   = bus.Msb_first;
          par_d   = bus.Par_type;
          state_d = SHIFT;
          if (tick) begin
            sh_d  = bus.Msb_first ? MAX_WIDTH'(bus.Sampled_bit)
                                  : {bus.Sampled_bit, {(MAX_WIDTH-1){1'b0}}};
            cnt_d = LEN_W'(1);
          end
        end
      end
      SHIFT: begin
        if (!bus.Deser_en) begin
          frag_d  = 1'b1;
          state_d = IDLE;
        end else if (tick) begin
          sh_d  = msb_q ? {sh_q[MAX_WIDTH-2:0], bus.Sampled_bit}
                        : {bus.Sampled_bit, sh_q[MAX_WIDTH-1:1]};
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q + LEN_W'(1) == len_q) begin
            state_d = WAIT_DROP;
            done_d  = 1'b1;
          end
        end
      end
      WAIT_DROP: begin
        if (!bus.Deser_en)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A load always wins over an acceptance; overrun only if nobody took the old word.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      p_data     <= '0;
      data_valid <= 1'b0;
      exp_par    <= 1'b0;
      frag_err   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frag_err <= frag_d;
      overrun  <= 1'b0;
      if (done_q) begin
        p_data     <= word;
        exp_par    <= par_word;
        data_valid <= 1'b1;
        overrun    <= data_valid && !bus.Rdy;
      end else if (data_valid && bus.Rdy) begin
        data_valid <= 1'b0;
      end
    end
  end

  assign bus.P_Data     = p_data;
  assign bus.Data_valid = data_valid;
  assign bus.Exp_par    = exp_par;
  assign bus.Frag_err   = frag_err;
  assign bus.Overrun    = overrun;

endmodule

// File: tb/tb_uart_rx_deser_v2.sv
// Directed bench for uart_rx_deser_v2 with hand-computed words and parity.
module tb_uart_rx_deser_v2;

  localparam int MAX_WIDTH = 9;
  localparam int CNT_W     = 6;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   period;

  uart_rx_deser_v2_if #(.MAX_WIDTH(MAX_WIDTH), .CNT_W(CNT_W)) bus ();

  uart_rx_deser_v2 #(.MAX_WIDTH(MAX_WIDTH), .CNT_W(CNT_W)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input logic [15:0] actual,
                              input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic set_cfg(input logic [3:0] len, input logic msb, input logic par);
    bus.Data_len  = len;
    bus.Msb_first = msb;
    bus.Par_type  = par;
  endtask

  // bits[i] is the i-th bit on the line; each bit spans one full oversample period.
  task automatic send_word(input logic [15:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      for (int e = 0; e < period; e++) begin
        bus.Deser_en    = 1'b1;
        bus.Sampled_bit = bits[i];
        bus.edgecount   = CNT_W'(e);
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic end_word();
    bus.Deser_en  = 1'b0;
    bus.edgecount = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic consume();
    bus.Rdy = 1'b1;
    @(posedge clk);
    #1;
    bus.Rdy = 1'b0;
  endtask

  task automatic check_word(input string tag, input logic [15:0] data, input logic par);
    check_output({tag, "_valid"}, 16'(bus.Data_valid), 16'd1);
    check_output({tag, "_data"},  16'(bus.P_Data), data);
    check_output({tag, "_par"},   16'(bus.Exp_par), 16'(par));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    period = 8;
    rst = 1'b0;
    bus.Sampled_bit = 1'b0;
    bus.Deser_en    = 1'b0;
    bus.Prescale    = 6'd8;
    bus.edgecount   = '0;
    bus.Rdy         = 1'b0;
    set_cfg(4'd8, 1'b0, 1'b0);
    #1;
    check_output("rst_data",  16'(bus.P_Data), 16'h0);
    check_output("rst_valid", 16'(bus.Data_valid), 16'h0);
    check_output("rst_par",   16'(bus.Exp_par), 16'h0);
    check_output("rst_flags", {14'd0, bus.Frag_err, bus.Overrun}, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // len 8, LSB-first, even: 0xA5, valid one cycle after the last tick
    send_word(16'h00A5, 8);
    check_output("a_latency", 16'(bus.Data_valid), 16'h0);
    end_word();
    check_word("a", 16'h00A5, 1'b0);
    check_output("a_ovr", 16'(bus.Overrun), 16'h0);
    consume();
    check_output("a_consumed", 16'(bus.Data_valid), 16'h0);
    check_output("a_hold", 16'(bus.P_Data), 16'h00A5);

    // len 7, MSB-first, odd: line 1,0,1,1,0,1,0 -> 0x5A
    set_cfg(4'd7, 1'b1, 1'b1);
    send_word(16'h002D, 7);
    end_word();
    check_word("b", 16'h005A, 1'b1);
    consume();

    // len 5, LSB-first, even: line 1,1,0,0,1 -> 0x13, left unconsumed
    set_cfg(4'd5, 1'b0, 1'b0);
    send_word(16'h0013, 5);
    end_word();
    check_word("c", 16'h0013, 1'b1);
    check_output("c_upper", 16'(bus.P_Data[8:5]), 16'h0);

    // fragment after 3 ticks keeps the pending word intact
    set_cfg(4'd8, 1'b0, 1'b0);
    send_word(16'h00FF, 3);
    end_word();
    check_output("d_frag", 16'(bus.Frag_err), 16'h1);
    check_word("d_keep", 16'h0013, 1'b1);
    @(posedge clk);
    #1;
    check_output("d_frag_pulse", 16'(bus.Frag_err), 16'h0);
    consume();
    send_word(16'h003C, 8);
    end_word();
    check_word("d_next", 16'h003C, 1'b0);
    consume();

    // back-to-back with Rdy low -> one overrun pulse
    send_word(16'h00A5, 8);
    end_word();
    check_output("e_first_ovr", 16'(bus.Overrun), 16'h0);
    send_word(16'h003C, 8);
    end_word();
    check_output("e_ovr", 16'(bus.Overrun), 16'h1);
    check_word("e", 16'h003C, 1'b0);
    @(posedge clk);
    #1;
    check_output("e_ovr_pulse", 16'(bus.Overrun), 16'h0);

    // acceptance in the completion cycle -> no overrun, new word valid
    send_word(16'h00A5, 8);
    bus.Rdy = 1'b1;
    end_word();
    bus.Rdy = 1'b0;
    check_output("e_acc_ovr", 16'(bus.Overrun), 16'h0);
    check_word("e_acc", 16'h00A5, 1'b0);
    consume();

    // Prescale=0 ticks at edgecount 63
    bus.Prescale = 6'd0;
    period = 64;
    send_word(16'h005B, 8);
    end_word();
    check_word("f_pre0", 16'h005B, 1'b1);
    consume();

    // Data_len=2 falls back to 9 bits
    bus.Prescale = 6'd8;
    period = 8;
    set_cfg(4'd2, 1'b0, 1'b0);
    send_word(16'h00A5, 8);
    for (int i = 0; i < 2; i++) begin
      bus.edgecount = '0;
      @(posedge clk);
      #1;
    end
    check_output("f_len_short", 16'(bus.Data_valid), 16'h0);
    send_word(16'h0001, 1);
    end_word();
    check_word("f_len9", 16'h01A5, 1'b1);

    // reset mid-word clears everything without a fragment pulse
    set_cfg(4'd8, 1'b0, 1'b0);
    send_word(16'h00FF, 4);
    rst = 1'b0;
    #1;
    check_output("g_data",  16'(bus.P_Data), 16'h0);
    check_output("g_valid", 16'(bus.Data_valid), 16'h0);
    check_output("g_par",   16'(bus.Exp_par), 16'h0);
    bus.Deser_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_output("g_frag", 16'(bus.Frag_err), 16'h0);
    check_output("g_idle", 16'(bus.Data_valid), 16'h0);
    send_word(16'h003C, 8);
    end_word();
    check_word("g_new", 16'h003C, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
